lifo_arbiter: RTL and testbench

LIFO_ARBITER -- requirements
Module: lifo_arbiter

---
 rtl/lifo_arb_pkg.sv | 8 +
 rtl/lifo_rr_arb.sv | 21 ++
 rtl/lifo_arbiter.sv | 104 ++++++++++
 tb/tb_lifo_arbiter.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/lifo_arb_pkg.sv
// lifo_arb_pkg: shared FSM/op types and parameter bounds for the LIFO arbiter
package lifo_arb_pkg;
    typedef enum logic [2:0] {IDLE, PUSH, POP, WAIT, RESP, REJECT} state_t;
    typedef enum logic {OP_PUSH, OP_POP} op_t;
    localparam int DATA_W_DEF  = 8;
    localparam int POP_LAT_MIN = 1;
    localparam int POP_LAT_MAX = 4;
endpackage

// File: rtl/lifo_rr_arb.sv
// lifo_rr_arb: 2-way arbiter, round-robin or fixed priority (LIFO_ARB_FIXED_PRIO_EN)
// clk, rst (async active-low); req: request vector; accept: winner is being
// serviced this cycle; win: one-hot winner (combinational).
module lifo_rr_arb (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] win
);
`ifdef LIFO_ARB_FIXED_PRIO_EN
    assign win = req[0] ? 2'b01 : {req[1], 1'b0};
`else
    logic prio;
    always_comb win = (&req) ? (prio ? 2'b10 : 2'b01) : req;
    // after serving requester 0, requester 1 gets priority and vice versa
    always_ff @(posedge clk or negedge rst)
        if (!rst) prio <= 1'b0;
        else if (accept && |win) prio <= win[0];
`endif
endmodule

// File: rtl/lifo_arbiter.sv
// lifo_arbiter: arbitrates two requesters' push/pop transactions onto one LIFO
// clk, rst (async active-low); push_req/pop_req/wdata0/wdata1 from requesters;
// grant/err/rvalid/rdata/busy back to requesters; lifo_* strobes, data and flags
// to/from the LIFO. Macro LIFO_ARB_FIXED_PRIO_EN selects fixed priority.
module lifo_arbiter
    import lifo_arb_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int POP_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        push_req,
    input  logic [1:0]        pop_req,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic [1:0]        grant,
    output logic [DATA_W-1:0] rdata,
    output logic [1:0]        rvalid,
    output logic [1:0]        err,
    output logic              busy,
    output logic              lifo_push,
    output logic              lifo_w_en,
    output logic              lifo_pop,
    output logic              lifo_r_en,
    output logic [DATA_W-1:0] lifo_datain,
    input  logic [DATA_W-1:0] lifo_out,
    input  logic              lifo_full,
    input  logic              lifo_empty
);
    state_t     state;
    logic       id;
    logic [1:0] cnt;
    logic [1:0] win;
    op_t        op;
    logic       reject;
    lifo_rr_arb u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (push_req | pop_req),
        .accept (state == IDLE),
        .win    (win)
    );
    // push beats pop within a single requester
    assign op        = push_req[win[1]] ? OP_PUSH : OP_POP;
    assign reject    = (op == OP_PUSH) ? lifo_full : lifo_empty;
    assign lifo_w_en = lifo_push;
    assign lifo_r_en = lifo_pop;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            id          <= 1'b0;
            cnt         <= '0;
            grant       <= '0;
            err         <= '0;
            rvalid      <= '0;
            busy        <= 1'b0;
            lifo_push   <= 1'b0;
            lifo_pop    <= 1'b0;
            lifo_datain <= '0;
            rdata       <= '0;
        end else begin
            grant     <= '0;
            err       <= '0;
            rvalid    <= '0;
            lifo_push <= 1'b0;
            lifo_pop  <= 1'b0;
            case (state)
                IDLE: if (|win) begin
                    id    <= win[1];
                    grant <= win;
                    busy  <= 1'b1;
                    if (reject) begin
                        state <= REJECT;
                        err   <= win;
                    end else if (op == OP_PUSH) begin
                        state       <= PUSH;
                        lifo_push   <= 1'b1;
                        lifo_datain <= win[1] ? wdata1 : wdata0;
                    end else begin
                        state    <= POP;
                        lifo_pop <= 1'b1;
                    end
                end
                POP: begin
                    state <= WAIT;
                    cnt   <= 2'(POP_LAT - 1);
                end
                // WAIT spans POP_LAT cycles; lifo_out is captured on its last edge
                WAIT: if (cnt == 2'd0) begin
                    state  <= RESP;
                    rdata  <= lifo_out;
                    rvalid <= id ? 2'b10 : 2'b01;
                end else begin
                    cnt <= cnt - 2'd1;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_lifo_arbiter.sv
// tb_lifo_arbiter: directed self-checking bench for lifo_arbiter
module tb_lifo_arbiter;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] push_req0 = '0, pop_req0 = '0;
    logic [7:0] wd00 = '0, wd01 = '0;
    logic [1:0] grant0, rvalid0, err0;
    logic [7:0] rdata0, datain0;
    logic       busy0, push0, wen0, pop0, ren0;
    logic       force_full = 1'b0, force_empty = 1'b0;
    logic [7:0] mem [16];
    logic [4:0] sp;
    logic [7:0] lo0;
    logic       full0, empty0;
    assign full0  = force_full || sp == 5'd16;
    assign empty0 = force_empty || sp == 5'd0;

    always @(posedge clk or negedge rst)
        if (!rst) begin
            sp  <= '0;
            lo0 <= '0;
        end else begin
            if (push0 && sp < 5'd16) begin
                mem[sp[3:0]] <= datain0;
                sp <= sp + 5'd1;
            end
            if (pop0 && sp > 5'd0) begin
                lo0 <= mem[sp[3:0] - 4'd1];
                sp  <= sp - 5'd1;
            end
        end

    lifo_arbiter #(.DATA_W(8), .POP_LAT(1)) u0 (
        .clk(clk), .rst(rst), .push_req(push_req0), .pop_req(pop_req0),
        .wdata0(wd00), .wdata1(wd01), .grant(grant0), .rdata(rdata0),
        .rvalid(rvalid0), .err(err0), .busy(busy0), .lifo_push(push0),
        .lifo_w_en(wen0), .lifo_pop(pop0), .lifo_r_en(ren0),
        .lifo_datain(datain0), .lifo_out(lo0), .lifo_full(full0),
        .lifo_empty(empty0)
    );

    logic [1:0] pop_req1 = '0;
    logic [1:0] grant1, rvalid1, err1;
    logic [7:0] rdata1, datain1;
    logic [7:0] lo1 = 8'hC3;
    logic       busy1, push1, wen1, pop1, ren1;

    lifo_arbiter #(.DATA_W(8), .POP_LAT(3)) u1 (
        .clk(clk), .rst(rst), .push_req(2'b00), .pop_req(pop_req1),
        .wdata0(8'h00), .wdata1(8'h00), .grant(grant1), .rdata(rdata1),
        .rvalid(rvalid1), .err(err1), .busy(busy1), .lifo_push(push1),
        .lifo_w_en(wen1), .lifo_pop(pop1), .lifo_r_en(ren1),
        .lifo_datain(datain1), .lifo_out(lo1), .lifo_full(1'b0),
        .lifo_empty(1'b0)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
    endtask

    task automatic wait_grant0(input int r, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (grant0[r]) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_push(input int r, input logic [7:0] v);
        bit ok;
        if (r == 1) wd01 = v; else wd00 = v;
        push_req0[r] = 1'b1;
        wait_grant0(r, ok);
        chk("push_grant", 32'(ok), 1);
        chk("push_strobes", {push0, wen0, pop0, ren0}, 4'b1100);
        chk("push_datain", datain0, v);
        push_req0[r] = 1'b0;
    endtask

    task automatic do_pop(input int r, input logic [7:0] v);
        bit ok;
        int c;
        pop_req0[r] = 1'b1;
        wait_grant0(r, ok);
        chk("pop_grant", 32'(ok), 1);
        chk("pop_strobes", {push0, wen0, pop0, ren0}, 4'b0011);
        pop_req0[r] = 1'b0;
        c = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            c++;
            if (rvalid0 != 2'b00) break;
        end
        chk("pop_rvalid", rvalid0, (r == 1) ? 2'b10 : 2'b01);
        chk("pop_latency", c, 2);
        chk("pop_rdata", rdata0, v);
    endtask

    initial begin
        bit         ok;
        logic [1:0] g, exp_g, rv_acc;
        int         c;
        repeat (2) tick();
        chk("rst_outputs", {grant0, rvalid0, err0, busy0, push0, wen0, pop0, ren0}, 0);
        chk("rst_data", {rdata0, datain0}, 0);
        rst = 1'b1;

        do_push(0, 8'h0A);
        do_push(0, 8'h0B);
        do_push(0, 8'h0C);
        do_pop(0, 8'h0C);
        do_pop(0, 8'h0B);
        do_pop(0, 8'h0A);

        do_reset();
        wd00 = 8'h10;
        wd01 = 8'h20;
        push_req0 = 2'b11;
        for (int k = 0; k < 6; k++) begin
            g = 2'b00;
            c = 0;
            for (int i = 0; i < 12 && g == 2'b00; i++) begin
                tick();
                c++;
                g = grant0;
            end
`ifdef LIFO_ARB_FIXED_PRIO_EN
            exp_g = 2'b01;
`else
            exp_g = (k % 2 == 1) ? 2'b10 : 2'b01;
`endif
            chk("rr_grant", g, exp_g);
            chk("rr_datain", datain0, exp_g[1] ? 8'h20 : 8'h10);
            if (k > 0) chk("rr_spacing", c, 2);
        end
        push_req0 = 2'b00;
        tick();

        force_full = 1'b1;
        wd01 = 8'h55;
        push_req0[1] = 1'b1;
        wait_grant0(1, ok);
        chk("full_grant", 32'(ok), 1);
        chk("full_err", err0, 2'b10);
        chk("full_no_push", {push0, wen0}, 2'b00);
        push_req0[1] = 1'b0;
        force_full = 1'b0;
        tick();

        force_empty = 1'b1;
        pop_req0[0] = 1'b1;
        wait_grant0(0, ok);
        chk("empty_grant", 32'(ok), 1);
        chk("empty_err", err0, 2'b01);
        chk("empty_no_pop", {pop0, ren0}, 2'b00);
        pop_req0[0] = 1'b0;
        rv_acc = 2'b00;
        for (int i = 0; i < 6; i++) begin
            tick();
            rv_acc = rv_acc | rvalid0;
        end
        chk("empty_no_rvalid", rv_acc, 2'b00);
        force_empty = 1'b0;

        pop_req1[1] = 1'b1;
        tick();
        chk("lat3_grant", grant1, 2'b10);
        chk("lat3_pop", {pop1, ren1}, 2'b11);
        pop_req1[1] = 1'b0;
        c = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            c++;
            if (rvalid1 != 2'b00) break;
        end
        chk("lat3_rvalid", rvalid1, 2'b10);
        chk("lat3_latency", c, 4);
        chk("lat3_rdata", rdata1, 8'hC3);
        tick();

        lo1 = 8'h3C;
        pop_req1[1] = 1'b1;
        tick();
        chk("abort_grant", grant1, 2'b10);
        pop_req1[1] = 1'b0;
        tick();
        chk("abort_in_wait", busy1, 1'b1);
        #2 rst = 1'b0;
        #1;
        chk("abort_outputs", {grant1, rvalid1, err1, busy1, push1, wen1, pop1, ren1}, 0);
        chk("abort_data", {rdata1, datain1}, 0);
        tick();
        rst = 1'b1;
        rv_acc = 2'b00;
        for (int i = 0; i < 8; i++) begin
            tick();
            rv_acc = rv_acc | rvalid1 | grant1 | err1;
        end
        chk("abort_no_stale", rv_acc, 2'b00);
        chk("abort_idle", busy1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
